// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multi-cycle signed multiply/divide unit.
package mult_div_pkg;

   localparam int MD_WIDTH = 32;
   localparam int MD_ITER  = 32;
   localparam int MD_CNT_W = $clog2(MD_ITER);
   localparam logic [MD_CNT_W-1:0] MD_CNT_LAST = MD_CNT_W'(MD_ITER - 1);

   typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} md_state_e;

   // Which result FIN has to commit.
   typedef enum logic [1:0] {OP_MULT, OP_DIV, OP_DZ} md_op_e;

   // Two's-complement magnitude; 0x80000000 maps to itself, which is the
   // correct unsigned magnitude.
   function automatic logic [MD_WIDTH-1:0] md_abs(input logic [MD_WIDTH-1:0] v);
      return v[MD_WIDTH-1] ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module restoring_div_step
   import mult_div_pkg::*;
(
   input  logic [MD_WIDTH-1:0] rem_i,
   input  logic [MD_WIDTH-1:0] quo_i,
   input  logic [MD_WIDTH-1:0] dvsr_i,
   output logic [MD_WIDTH-1:0] rem_o,
   output logic [MD_WIDTH-1:0] quo_o
);

   logic [MD_WIDTH:0] shifted;
   logic [MD_WIDTH:0] trial;

   // Shift the next dividend bit in, trial-subtract, keep the old value on borrow.
   always_comb begin
      shifted = {rem_i, quo_i[MD_WIDTH-1]};
      trial   = shifted - {1'b0, dvsr_i};
      rem_o   = trial[MD_WIDTH] ? shifted[MD_WIDTH-1:0] : trial[MD_WIDTH-1:0];
      quo_o   = {quo_i[MD_WIDTH-2:0], ~trial[MD_WIDTH]};
   end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) unit
// producing HI/LO. The divider is compiled in only when MULT_DIV_DIVIDER_EN
// is defined; otherwise start_div is ignored and div_zero is tied low.
module mult_div_unit
   import mult_div_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                start_mult,
   input  logic                start_div,
   input  logic [MD_WIDTH-1:0] operand_a,
   input  logic [MD_WIDTH-1:0] operand_b,
   output logic [MD_WIDTH-1:0] hi_out,
   output logic [MD_WIDTH-1:0] lo_out,
   output logic                busy,
   output logic                done,
   output logic                div_zero
);

   md_state_e             state_q;
   md_op_e                op_q;
   logic [MD_CNT_W-1:0]   cnt_q;
   logic [2*MD_WIDTH:0]   acc_q, acc_d;     // {upper, multiplier, q-1}
   logic [MD_WIDTH-1:0]   mcand_q;
   logic [MD_WIDTH-1:0]   hi_q, lo_q;
   logic                  done_q, dz_q;
   logic [MD_WIDTH:0]     booth_sum;

`ifdef MULT_DIV_DIVIDER_EN
   logic [MD_WIDTH-1:0]   rem_q, quo_q, dvsr_q;
   logic [MD_WIDTH-1:0]   rem_nx, quo_nx;
   logic                  qneg_q, rneg_q;

   restoring_div_step u_div_step (
      .rem_i  (rem_q),
      .quo_i  (quo_q),
      .dvsr_i (dvsr_q),
      .rem_o  (rem_nx),
      .quo_o  (quo_nx)
   );
`else
   logic unused_start_div;
   assign unused_start_div = start_div;
`endif

   // Booth step: the add/sub is done at 33 bits so the arithmetic shift keeps
   // the true sign even when the upper half overflows 32 bits.
   always_comb begin
      booth_sum = {acc_q[2*MD_WIDTH], acc_q[2*MD_WIDTH:MD_WIDTH+1]};
      case (acc_q[1:0])
         2'b01:   booth_sum = booth_sum + {mcand_q[MD_WIDTH-1], mcand_q};
         2'b10:   booth_sum = booth_sum - {mcand_q[MD_WIDTH-1], mcand_q};
         default: booth_sum = booth_sum;
      endcase
      acc_d = {booth_sum, acc_q[MD_WIDTH:1]};
   end

   // Control FSM with the iterating datapath and registered results.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         op_q    <= OP_MULT;
         cnt_q   <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
`ifdef MULT_DIV_DIVIDER_EN
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_mult) begin
                  acc_q   <= {{MD_WIDTH{1'b0}}, operand_b, 1'b0};
                  mcand_q <= operand_a;
                  cnt_q   <= '0;
                  op_q    <= OP_MULT;
                  state_q <= MULT;
               end
`ifdef MULT_DIV_DIVIDER_EN
               else if (start_div) begin
                  if (operand_b == '0) begin
                     op_q    <= OP_DZ;
                     state_q <= FIN;
                  end else begin
                     quo_q   <= md_abs(operand_a);
                     dvsr_q  <= md_abs(operand_b);
                     rem_q   <= '0;
                     qneg_q  <= operand_a[MD_WIDTH-1] ^ operand_b[MD_WIDTH-1];
                     rneg_q  <= operand_a[MD_WIDTH-1];
                     cnt_q   <= '0;
                     op_q    <= OP_DIV;
                     state_q <= DIV;
                  end
               end
`endif
            end
            MULT: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == MD_CNT_LAST) state_q <= FIN;
            end
`ifdef MULT_DIV_DIVIDER_EN
            DIV: begin
               rem_q <= rem_nx;
               quo_q <= quo_nx;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == MD_CNT_LAST) state_q <= FIN;
            end
`endif
            FIN: begin
               done_q  <= 1'b1;
               state_q <= IDLE;
               case (op_q)
                  OP_MULT: begin
                     hi_q <= acc_q[2*MD_WIDTH:MD_WIDTH+1];
                     lo_q <= acc_q[MD_WIDTH:1];
                  end
`ifdef MULT_DIV_DIVIDER_EN
                  OP_DIV: begin
                     lo_q <= qneg_q ? -quo_q : quo_q;
                     hi_q <= rneg_q ? -rem_q : rem_q;
                  end
                  OP_DZ: dz_q <= 1'b1;
`endif
                  default: ;
               endcase
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign hi_out   = hi_q;
   assign lo_out   = lo_q;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed and random multiply/divide
// operations against a plain-arithmetic reference model. Expectations follow
// the MULT_DIV_DIVIDER_EN setting of the build.
module tb_mult_div_unit;

`ifdef MULT_DIV_DIVIDER_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start_mult, start_div;
   logic [31:0] operand_a, operand_b;
   logic [31:0] hi_out, lo_out;
   logic        busy, done, div_zero;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] exp_hi = 32'h0;
   logic [31:0] exp_lo = 32'h0;

   always #5 clk = ~clk;

   mult_div_unit dut (
      .clk        (clk),
      .reset      (reset),
      .start_mult (start_mult),
      .start_div  (start_div),
      .operand_a  (operand_a),
      .operand_b  (operand_b),
      .hi_out     (hi_out),
      .lo_out     (lo_out),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference: signed 64-bit product; truncating division with the
   // remainder taking the dividend's sign (done in 64 bits so the
   // 0x80000000 / -1 case simply wraps).
   task automatic model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l);
      longint sa, sb, p, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (is_mult) begin
         p = sa * sb;
         h = p[63:32];
         l = p[31:0];
      end else begin
         q = sa / sb;
         r = sa % sb;
         h = r[31:0];
         l = q[31:0];
      end
   endtask

   // kind: 0 = mult, 1 = div. both: raise both starts. inj_at: edge index
   // (1..32) at which a stray start_div/0 is pulsed mid-operation, 0 = none.
   task automatic run_op(input string tag, input int kind, input bit both, input int inj_at,
                         input logic [31:0] a, input logic [31:0] b);
      bit          is_mult, is_dz, is_none;
      int          exp_lat, done_edge, busy_cnt;
      bit          stable;
      logic [31:0] prev_hi, prev_lo, mh, ml;

      is_mult = (kind == 0) || both;
      is_none = !is_mult && !DIV_EN;
      is_dz   = !is_mult && DIV_EN && (b == 32'h0);
      exp_lat = is_none ? 0 : (is_dz ? 1 : 33);
      if (is_mult || (DIV_EN && !is_dz)) begin
         model(is_mult, a, b, mh, ml);
      end else begin
         mh = exp_hi;
         ml = exp_lo;
      end

      prev_hi = hi_out;
      prev_lo = lo_out;
      stable  = 1'b1;

      @(negedge clk);
      start_mult = is_mult;
      start_div  = (kind == 1) || both;
      operand_a  = a;
      operand_b  = b;
      @(posedge clk); #1;
      start_mult = 1'b0;
      start_div  = 1'b0;
      operand_a  = $urandom;
      operand_b  = $urandom;
      busy_cnt   = busy ? 1 : 0;
      done_edge  = 0;

      for (int e = 1; e <= 40 && done_edge == 0; e++) begin
         if (e == inj_at) begin
            start_div = 1'b1;
            operand_b = 32'h0;
         end
         @(posedge clk); #1;
         start_div = 1'b0;
         if (done) done_edge = e;
         else begin
            if (busy) busy_cnt++;
            if (hi_out !== prev_hi || lo_out !== prev_lo) stable = 1'b0;
         end
      end

      exp_hi = mh;
      exp_lo = ml;
      chk({tag, "_done_edge"}, 64'(done_edge), 64'(exp_lat));
      chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
      chk({tag, "_busy_at_done"}, 64'(busy), 64'(0));
      chk({tag, "_div_zero"}, 64'(div_zero), 64'(is_dz));
      chk({tag, "_stable"}, 64'(stable), 64'(1));
      chk({tag, "_hi"}, 64'(hi_out), 64'(exp_hi));
      chk({tag, "_lo"}, 64'(lo_out), 64'(exp_lo));
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, {62'h0, done, div_zero}, 64'h0);
   endtask

   initial begin
      reset      = 1'b0;
      start_mult = 1'b0;
      start_div  = 1'b0;
      operand_a  = 32'h0;
      operand_b  = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hi", 64'(hi_out), 64'h0);
      chk("rst_lo", 64'(lo_out), 64'h0);
      chk("rst_flags", {61'h0, busy, done, div_zero}, 64'h0);
      @(negedge clk);
      reset = 1'b1;

      // Directed cases.
      run_op("mul_7_m3", 0, 1'b0, 0, 32'h00000007, 32'hFFFFFFFD);
      chk("mul_7_m3_const", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFEB);
      run_op("mul_max", 0, 1'b0, 0, 32'h7FFFFFFF, 32'h7FFFFFFF);
      chk("mul_max_const", {hi_out, lo_out}, 64'h3FFFFFFF_00000001);
      run_op("mul_min", 0, 1'b0, 0, 32'h80000000, 32'h80000000);
      run_op("mul_minx1", 0, 1'b0, 0, 32'h80000000, 32'h00000001);
      run_op("div_m7_2", 1, 1'b0, 0, 32'hFFFFFFF9, 32'h00000002);
      run_op("div_ovf", 1, 1'b0, 0, 32'h80000000, 32'hFFFFFFFF);
      run_op("div_7_m2", 1, 1'b0, 0, 32'h00000007, 32'hFFFFFFFE);
      run_op("mul_pre", 0, 1'b0, 0, 32'h12345678, 32'h00000100);
      run_op("div_by0", 1, 1'b0, 0, 32'h00000005, 32'h00000000);
      run_op("mul_inj", 0, 1'b0, 5, 32'hFFFF0001, 32'h00007FFF);
      run_op("both", 1, 1'b1, 0, 32'hFFFFFFF5, 32'h00000009);

      // Random operations.
      for (int i = 0; i < 12; i++) begin
         logic [31:0] ra, rb;
         int          k;
         k  = int'($urandom_range(0, 1));
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 2) == 0) rb = {{16{rb[15]}}, rb[15:0]} >>> $urandom_range(0, 14);
         if ($urandom_range(0, 7) == 0) rb = 32'h0;
         run_op(k == 0 ? "rnd_mul" : "rnd_div", k, 1'b0, 0, ra, rb);
      end

      // Reset during a multiply: preload nonzero HI/LO first.
      run_op("mul_pre2", 0, 1'b0, 0, 32'hDEADBEEF, 32'h00001234);
      @(negedge clk);
      start_mult = 1'b1;
      operand_a  = 32'h00000003;
      operand_b  = 32'h00000005;
      @(posedge clk); #1;
      start_mult = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_hi", 64'(hi_out), 64'h0);
      chk("midrst_lo", 64'(lo_out), 64'h0);
      chk("midrst_flags", {61'h0, busy, done, div_zero}, 64'h0);
      exp_hi = 32'h0;
      exp_lo = 32'h0;
      @(negedge clk);
      reset = 1'b1;
      run_op("mul_after_rst", 0, 1'b0, 0, 32'hFFFFFFFE, 32'h00000011);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
